div_scheduler: RTL and testbench

- Controller and arbiter that shares one multi-cycle restoring divider unit between two requesters.
- Accepts level requests carrying dividend/divisor and arbitrates round-robin.
- Issues the divider's init pulse, waits for its done, and returns quotient plus error flag with a one-cycle ack.
- Sits between the ALU operation decoder (requester 0) and the test/UART port (requester 1) on one side and the divider instance on the other.

---
 rtl/div_scheduler_pkg.sv | 18 +
 rtl/div_scheduler_rr_arb2.sv | 38 +++
 rtl/div_scheduler.sv | 155 +++++++++++++++
 tb/tb_div_scheduler.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/div_scheduler_pkg.sv
// Shared types and constants for the divider scheduler: FSM encoding,
// default operand width, timer width and the divide-by-zero result pattern.
package div_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int W_DEF = 3;
  localparam int TMR_W = 5;

  // Truncated to the operand width at the point of use, so it stays all ones.
  localparam logic [31:0] DIV0_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_scheduler_rr_arb2.sv
// Two-input round-robin arbiter. On a tie the port that did not win last time
// is granted; the last-grant memory only advances when i_en accepts a grant.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  logic       r_last;
  logic [1:0] w_gnt;

  // Grant selection from current requests and last winner
  always_comb begin
    w_gnt = 2'b00;
    case (i_req)
      2'b01:   w_gnt = 2'b01;
      2'b10:   w_gnt = 2'b10;
      2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
      default: w_gnt = 2'b00;
    endcase
  end

  assign o_gnt = w_gnt;

  // Last-grant memory; reset to port 1 so port 0 wins the first tie
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= 1'b1;
    end else if (i_en && (w_gnt != 2'b00)) begin
      r_last <= w_gnt[1];
    end else begin
      r_last <= r_last;
    end
  end

endmodule

// File: rtl/div_scheduler.sv
// Shares one multi-cycle divider between two requesters: arbitrates, issues the
// init pulse, waits for done (with stale-done skip and timeout), returns an ack.
module div_scheduler
  import div_scheduler_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int TMO  = 31,
  parameter int SKIP = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_req0,
  input  logic [W-1:0] i_dv0,
  input  logic [W-1:0] i_dr0,
  input  logic         i_req1,
  input  logic [W-1:0] i_dv1,
  input  logic [W-1:0] i_dr1,
  output logic         o_ack0,
  output logic         o_ack1,
  output logic [W-1:0] o_res,
  output logic         o_err,
  output logic         o_busy,
  output logic         o_unit_init,
  output logic [W-1:0] o_unit_dv,
  output logic [W-1:0] o_unit_dr,
  input  logic [W-1:0] i_unit_q,
  input  logic         i_unit_done
);

  localparam logic [TMR_W-1:0] SKIP_T = TMR_W'(SKIP);
  localparam logic [TMR_W-1:0] TMO_T  = TMR_W'(TMO);

  state_t             r_state, w_state;
  logic [TMR_W-1:0]   r_timer, w_timer;
  logic               r_ack0, w_ack0, r_ack1, w_ack1;
  logic [W-1:0]       r_res, w_res;
  logic               r_err, w_err;
  logic               r_busy, w_busy;
  logic               r_init, w_init;
  logic [W-1:0]       r_dv, w_dv, r_dr, w_dr;
  logic               r_gsel, w_gsel;
  logic               w_arb_en;
  logic [1:0]         w_gnt;

  rr_arb2 u_arb (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_req ({i_req1, i_req0}),
    .i_en  (w_arb_en),
    .o_gnt (w_gnt)
  );

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    w_state  = r_state;
    w_timer  = r_timer;
    w_ack0   = 1'b0;
    w_ack1   = 1'b0;
    w_res    = '0;
    w_err    = 1'b0;
    w_init   = 1'b0;
    w_dv     = r_dv;
    w_dr     = r_dr;
    w_gsel   = r_gsel;
    w_arb_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_arb_en = 1'b1;
        if (w_gnt != 2'b00) begin
          w_gsel = w_gnt[1];
          w_dv   = w_gnt[1] ? i_dv1 : i_dv0;
          w_dr   = w_gnt[1] ? i_dr1 : i_dr0;
          if (w_dr == '0) begin
            w_res   = W'(DIV0_ONES);
            w_err   = 1'b1;
            w_ack0  = ~w_gnt[1];
            w_ack1  = w_gnt[1];
            w_state = S_RESP;
          end else begin
            w_init  = 1'b1;
            w_state = S_ISSUE;
          end
        end else begin
          w_state = S_IDLE;
        end
      end
      S_ISSUE: begin
        w_timer = '0;
        w_state = S_WAIT;
      end
      S_WAIT: begin
        // A done inside the skip window belongs to the previous operation
        if ((r_timer >= SKIP_T) && i_unit_done) begin
          w_res   = i_unit_q;
          w_ack0  = ~r_gsel;
          w_ack1  = r_gsel;
          w_state = S_RESP;
        end else if (r_timer == TMO_T) begin
          w_err   = 1'b1;
          w_ack0  = ~r_gsel;
          w_ack1  = r_gsel;
          w_state = S_RESP;
        end else begin
          w_timer = r_timer + 1'b1;
        end
      end
      S_RESP: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
    w_busy = (w_state != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_res   <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_init  <= 1'b0;
      r_dv    <= '0;
      r_dr    <= '0;
      r_gsel  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_timer <= w_timer;
      r_ack0  <= w_ack0;
      r_ack1  <= w_ack1;
      r_res   <= w_res;
      r_err   <= w_err;
      r_busy  <= w_busy;
      r_init  <= w_init;
      r_dv    <= w_dv;
      r_dr    <= w_dr;
      r_gsel  <= w_gsel;
    end
  end

  assign o_ack0      = r_ack0;
  assign o_ack1      = r_ack1;
  assign o_res       = r_res;
  assign o_err       = r_err;
  assign o_busy      = r_busy;
  assign o_unit_init = r_init;
  assign o_unit_dv   = r_dv;
  assign o_unit_dr   = r_dr;

endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler with a behavioural divider model that
// computes the quotient itself and can hold a stale done or never finish.
module tb_div_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [2:0] dv0, dr0, dv1, dr1;
  logic       ack0, ack1, err, busy, unit_init, unit_done;
  logic [2:0] res, unit_dv, unit_dr, unit_q;

  int         checks = 0;
  int         errors = 0;
  int         last_lat = 0;
  int         m_lat = 8;
  int         m_stale = 0;
  logic       m_act;
  logic [7:0] m_cnt;

  always #5 clk = ~clk;

  div_scheduler dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req0      (req0),
    .i_dv0       (dv0),
    .i_dr0       (dr0),
    .i_req1      (req1),
    .i_dv1       (dv1),
    .i_dr1       (dr1),
    .o_ack0      (ack0),
    .o_ack1      (ack1),
    .o_res       (res),
    .o_err       (err),
    .o_busy      (busy),
    .o_unit_init (unit_init),
    .o_unit_dv   (unit_dv),
    .o_unit_dr   (unit_dr),
    .i_unit_q    (unit_q),
    .i_unit_done (unit_done)
  );

  // Divider model: done m_lat cycles after init (0 = never), stale done kept m_stale cycles
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      unit_done <= 1'b0;
      unit_q    <= 3'd0;
      m_act     <= 1'b0;
      m_cnt     <= 8'd0;
    end else if (unit_init) begin
      m_act <= 1'b1;
      m_cnt <= 8'd0;
      if (m_stale == 0) unit_done <= 1'b0;
    end else if (m_act) begin
      m_cnt <= m_cnt + 8'd1;
      if (m_stale != 0 && (m_cnt + 8'd1) == 8'(m_stale)) unit_done <= 1'b0;
      if (m_lat != 0 && (m_cnt + 8'd1) == 8'(m_lat)) begin
        unit_done <= 1'b1;
        unit_q    <= (unit_dr == 3'd0) ? 3'b111 : unit_dv / unit_dr;
        m_act     <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int port, input logic [2:0] exp_res, input logic exp_err,
                          input string tag);
    int n = 0;
    while (!(ack0 || ack1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    last_lat = n;
    check({tag, "_seen"}, 32'(ack0 || ack1), 32'd1);
    check({tag, "_port"}, 32'({ack1, ack0}), (port == 0) ? 32'd1 : 32'd2);
    check({tag, "_res"}, 32'(res), 32'(exp_res));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    if (port == 0) req0 = 1'b0;
    else req1 = 1'b0;
    @(negedge clk);
    check({tag, "_ackclr"}, 32'({ack1, ack0, res, err}), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    dv0 = 3'd0; dr0 = 3'd0; dv1 = 3'd0; dr1 = 3'd0;
    repeat (2) @(negedge clk);
    check("rst_outs", 32'({ack0, ack1, res, err, busy, unit_init, unit_dv, unit_dr}), 32'd0);

    // Single request 6/2
    rst = 1'b0;
    req0 = 1'b1; dv0 = 3'd6; dr0 = 3'd2;
    @(negedge clk);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_init", 32'(unit_init), 32'd1);
    check("t1_ops", 32'({unit_dv, unit_dr}), 32'({3'd6, 3'd2}));
    @(negedge clk);
    check("t1_init_pulse", 32'(unit_init), 32'd0);
    wait_ack(0, 3'd3, 1'b0, "t1");
    @(negedge clk);
    check("t1_no_double", 32'({ack0, ack1, busy}), 32'd0);

    // Simultaneous pairs from a fresh last_grant
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b1; dv0 = 3'd6; dr0 = 3'd3;
    req1 = 1'b1; dv1 = 3'd7; dr1 = 3'd2;
    wait_ack(0, 3'd2, 1'b0, "pairA0");
    wait_ack(1, 3'd3, 1'b0, "pairA1");
    req0 = 1'b1; req1 = 1'b1;
    wait_ack(0, 3'd2, 1'b0, "pairB0");
    wait_ack(1, 3'd3, 1'b0, "pairB1");

    // Divide by zero bypasses the unit
    req1 = 1'b1; dv1 = 3'd5; dr1 = 3'd0;
    @(negedge clk);
    check("dz_ack", 32'({ack1, ack0}), 32'd2);
    check("dz_res_err", 32'({res, err}), 32'({3'b111, 1'b1}));
    check("dz_noinit", 32'(unit_init), 32'd0);
    check("dz_ops", 32'({unit_dv, unit_dr}), 32'({3'd5, 3'd0}));
    req1 = 1'b0;
    @(negedge clk);
    check("dz_end", 32'({ack1, busy, unit_init}), 32'd0);

    // Stale done from previous op (q=3) must be ignored; new quotient 7/1
    m_stale = 1;
    req0 = 1'b1; dv0 = 3'd7; dr0 = 3'd1;
    wait_ack(0, 3'd7, 1'b0, "stale");
    m_stale = 0;

    // Unit never finishes -> timeout
    m_lat = 0;
    req1 = 1'b1; dv1 = 3'd4; dr1 = 3'd2;
    wait_ack(1, 3'd0, 1'b1, "tmo");
    check("tmo_lat", 32'(last_lat >= 32 && last_lat <= 35), 32'd1);
    m_lat = 5;
    req0 = 1'b1; dv0 = 3'd5; dr0 = 3'd2;
    wait_ack(0, 3'd2, 1'b0, "after_tmo");

    // Async reset in WAIT, then re-service of the held request
    m_lat = 8;
    req0 = 1'b1; dv0 = 3'd6; dr0 = 3'd2;
    repeat (4) @(negedge clk);
    check("rm_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1 check("rm_outs", 32'({ack0, ack1, res, err, busy, unit_init, unit_dv, unit_dr}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ack(0, 3'd3, 1'b0, "rm_again");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
